// File: rtl/pipeline_hold_unit.sv
// rtl/pipeline_hold_unit.sv - PC, IF/ID and ID/EX registers with hazard hold, flush, bubble and stall-protocol checking
module pipeline_hold_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_hold,
  input  logic        Instruction_hold,
  input  logic        Stall_Control,
  input  logic        Flush_D,
  input  logic [31:0] PC_Next,
  input  logic [31:0] Instruction_F,
  input  logic [9:0]  Ctrl_D,
  input  logic [4:0]  Rt_D,
  output logic [31:0] PC,
  output logic [31:0] Instruction_D,
  output logic [31:0] PCPlus4_D,
  output logic [9:0]  Ctrl_Ex,
  output logic [4:0]  Rt_Ex,
  output logic        MemRead_Ex,
  output logic [15:0] Stall_Count,
  output logic        Stall_Error
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_ERR   = 2'b10;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [9:0]  ctrl_q, ctrl_d;
  logic [4:0]  rt_q, rt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  state_q, state_d;
  logic        hold_mismatch;

  always_comb begin
    pc_d = PC_hold ? pc_q : PC_Next;

    // Hold outranks flush; a flush seen during hold is simply dropped.
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (!Instruction_hold) begin
      if (Flush_D) begin
        instr_d = 32'h0000_0000;
        pc4_d   = 32'h0000_0000;
      end else begin
        instr_d = Instruction_F;
        pc4_d   = pc_q + 32'd4;
      end
    end

    ctrl_d = Stall_Control ? 10'd0 : Ctrl_D;
    rt_d   = Stall_Control ? 5'd0  : Rt_D;

    cnt_d = cnt_q;
    if (Stall_Control && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    hold_mismatch = !((PC_hold == Instruction_hold) && (Instruction_hold == Stall_Control));

    state_d = state_q;
    case (state_q)
      ST_RUN:   state_d = Stall_Control ? ST_STALL : ST_RUN;
      ST_STALL: state_d = Stall_Control ? ST_ERR : ST_RUN;
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_ERR;
    endcase
    if (hold_mismatch) begin
      state_d = ST_ERR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= 32'h0000_0000;
      instr_q <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      ctrl_q  <= 10'd0;
      rt_q    <= 5'd0;
      cnt_q   <= 16'd0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      ctrl_q  <= ctrl_d;
      rt_q    <= rt_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign PC            = pc_q;
  assign Instruction_D = instr_q;
  assign PCPlus4_D     = pc4_q;
  assign Ctrl_Ex       = ctrl_q;
  assign Rt_Ex         = rt_q;
  assign MemRead_Ex    = ctrl_q[2];
  assign Stall_Count   = cnt_q;
  assign Stall_Error   = (state_q == ST_ERR);

endmodule
